// File: rtl/ifm_strip_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifm_strip_feeder_pkg
// Description : Frame geometry, strip constants and FSM state type shared
//               by the IFM strip feeder and the downstream conv array.
// Revision    : 1.0 - initial release
// ============================================================================
package ifm_strip_feeder_pkg;

  localparam int IMG_W    = 50;
  localparam int IMG_H    = 50;
  localparam int ROWS     = 7;
  localparam int STRIDE   = 5;
  localparam int OUT_W    = IMG_W - 2;
  localparam int OUT_H    = IMG_H - 2;
  localparam int N_STRIPS = (OUT_H + STRIDE - 1) / STRIDE;

  localparam int COL_W    = $clog2(IMG_W);
  localparam int ROW_W    = $clog2(IMG_H + 1);
  localparam int BANK_W   = $clog2(ROWS);
  localparam int NEED_W   = $clog2(ROWS + 1);
  localparam int STRIP_W  = $clog2(N_STRIPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Physical bank that holds logical row k when the ring starts at base.
  function automatic logic [BANK_W-1:0] bank_of(input logic [BANK_W-1:0] base, input int k);
    return BANK_W'((int'(base) + k) % ROWS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ifm_strip_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : ifm_strip_feeder_if
// Description : Pixel stream input, frame control and PE window outputs of
//               the IFM strip feeder.
// Revision    : 1.0 - initial release
// ============================================================================
interface ifm_strip_feeder_if;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [23:0] pe_1;
  logic [23:0] pe_2;
  logic [23:0] pe_3;
  logic [23:0] pe_4;
  logic [23:0] pe_5;
  logic [23:0] pe_6;
  logic [23:0] pe_7;
  logic        pe_valid;
  logic        strip_done;
  logic        frame_done;
  logic        busy;

  modport slave (
    input  start, s_data, s_valid,
    output s_ready, pe_1, pe_2, pe_3, pe_4, pe_5, pe_6, pe_7,
    output pe_valid, strip_done, frame_done, busy
  );

  modport master (
    output start, s_data, s_valid,
    input  s_ready, pe_1, pe_2, pe_3, pe_4, pe_5, pe_6, pe_7,
    input  pe_valid, strip_done, frame_done, busy
  );
endinterface
`default_nettype wire

// File: rtl/ifm_strip_feeder_row_bank_mem.sv
`default_nettype none
// ============================================================================
// Module      : row_bank_mem
// Description : One image row of byte storage with a single write port and
//               three adjacent combinational read taps (c, c+1, c+2).
// Revision    : 1.0 - initial release
// ============================================================================
module row_bank_mem #(
  parameter int W  = 50,
  parameter int AW = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [23:0]   taps
);

  logic [7:0] r_mem [W];
  logic [AW:0] w_addr [3];

  // Pixel write; contents need no reset since validity is tracked per bank.
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
  end

  // Three adjacent taps, col c in the top byte; reads past the row end give 0.
  always_comb begin
    taps = '0;
    for (int i = 0; i < 3; i++) begin
      w_addr[i] = {1'b0, raddr} + (AW+1)'(i);
      if (w_addr[i] < (AW+1)'(W)) taps[23-8*i -: 8] = r_mem[w_addr[i][AW-1:0]];
    end
  end

endmodule
`default_nettype wire

// File: rtl/ifm_strip_feeder.sv
`default_nettype none
// ============================================================================
// Module      : ifm_strip_feeder
// Description : Buffers 7 IFM rows in a rotating bank ring and streams 3x7
//               pixel windows to the PE array, one strip of 5 output rows
//               at a time, zero-padding rows below the image.
// Revision    : 1.0 - initial release
// ============================================================================
module ifm_strip_feeder
  import ifm_strip_feeder_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  ifm_strip_feeder_if.slave bus
);

  state_t               r_state, w_state_nxt;
  logic [BANK_W-1:0]    r_base;
  logic [ROW_W-1:0]     r_in_row;
  logic [STRIP_W-1:0]   r_strip_cnt;
  logic [ROWS-1:0]      r_row_ok;
  logic [NEED_W-1:0]    r_need;
  logic [COL_W-1:0]     r_col;
  logic [COL_W-1:0]     r_c;
  logic [23:0]          r_pe [ROWS];
  logic                 r_pe_valid, r_strip_done, r_frame_done, r_busy;

  logic                 w_s_ready, w_accept, w_pad, w_row_end;
  logic                 w_emit_win, w_last_strip;
  logic [BANK_W-1:0]    w_fill_bank;
  logic [ROWS-1:0]      w_we;
  logic [23:0]          w_taps [ROWS];
  logic [23:0]          w_win  [ROWS];

  assign w_accept     = w_s_ready && bus.s_valid;
  assign w_pad        = (r_state == FILL) && (r_need != '0) && (r_in_row == ROW_W'(IMG_H));
  assign w_row_end    = w_accept && (r_col == COL_W'(IMG_W - 1));
  assign w_fill_bank  = bank_of(r_base, ROWS - int'(r_need));
  assign w_emit_win   = (r_state == EMIT) && (r_c < COL_W'(OUT_W));
  assign w_last_strip = (r_strip_cnt == STRIP_W'(N_STRIPS - 1));

  for (genvar b = 0; b < ROWS; b++) begin : g_bank
    assign w_we[b] = w_accept && (w_fill_bank == BANK_W'(b));
    row_bank_mem #(.W(IMG_W), .AW(COL_W)) u_mem (
      .clk   (clk),
      .we    (w_we[b]),
      .waddr (r_col),
      .wdata (bus.s_data),
      .raddr (r_c),
      .taps  (w_taps[b])
    );
  end

  // Map logical rows onto the bank ring; banks without image data read as 0.
  always_comb begin
    for (int k = 0; k < ROWS; k++) begin
      w_win[k] = r_row_ok[bank_of(r_base, k)] ? w_taps[bank_of(r_base, k)] : 24'h0;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and stream ready.
  always_comb begin
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    case (r_state)
      IDLE: if (bus.start) w_state_nxt = FILL;
      FILL: begin
        w_s_ready = (r_need != '0) && (r_in_row < ROW_W'(IMG_H));
        if (r_need == '0) w_state_nxt = EMIT;
      end
      EMIT: if (!w_emit_win) w_state_nxt = w_last_strip ? IDLE : FILL;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Fill bookkeeping, bank rotation, window output registers and pulses.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_base       <= '0;
      r_in_row     <= '0;
      r_strip_cnt  <= '0;
      r_row_ok     <= '0;
      r_need       <= '0;
      r_col        <= '0;
      r_c          <= '0;
      r_pe_valid   <= 1'b0;
      r_strip_done <= 1'b0;
      r_frame_done <= 1'b0;
      r_busy       <= 1'b0;
      for (int k = 0; k < ROWS; k++) r_pe[k] <= '0;
    end else begin
      r_pe_valid   <= 1'b0;
      r_strip_done <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_busy      <= 1'b1;
            r_need      <= NEED_W'(ROWS);
            r_base      <= '0;
            r_in_row    <= '0;
            r_strip_cnt <= '0;
            r_col       <= '0;
          end
        end
        FILL: begin
          if (w_accept) begin
            r_col <= w_row_end ? '0 : r_col + COL_W'(1);
            if (w_row_end) begin
              r_row_ok[w_fill_bank] <= 1'b1;
              r_in_row <= r_in_row + ROW_W'(1);
              r_need   <= r_need - NEED_W'(1);
            end
          end else if (w_pad) begin
            r_row_ok[w_fill_bank] <= 1'b0;
            r_need <= r_need - NEED_W'(1);
          end
          if (r_need == '0) r_c <= '0;
        end
        EMIT: begin
          if (w_emit_win) begin
            for (int k = 0; k < ROWS; k++) r_pe[k] <= w_win[k];
            r_pe_valid <= 1'b1;
            r_c <= r_c + COL_W'(1);
          end else begin
            r_strip_done <= 1'b1;
            r_strip_cnt  <= r_strip_cnt + STRIP_W'(1);
            if (w_last_strip) begin
              r_frame_done <= 1'b1;
              r_busy       <= 1'b0;
              r_base       <= '0;
              r_in_row     <= '0;
            end else begin
              r_base <= bank_of(r_base, STRIDE);
              r_need <= NEED_W'(STRIDE);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.s_ready    = w_s_ready;
  assign bus.pe_1       = r_pe[0];
  assign bus.pe_2       = r_pe[1];
  assign bus.pe_3       = r_pe[2];
  assign bus.pe_4       = r_pe[3];
  assign bus.pe_5       = r_pe[4];
  assign bus.pe_6       = r_pe[5];
  assign bus.pe_7       = r_pe[6];
  assign bus.pe_valid   = r_pe_valid;
  assign bus.strip_done = r_strip_done;
  assign bus.frame_done = r_frame_done;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_ifm_strip_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifm_strip_feeder
// Description : Self-checking bench for ifm_strip_feeder against a strip /
//               window reference computed from image coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifm_strip_feeder;
  import ifm_strip_feeder_pkg::*;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  ifm_strip_feeder_if bus ();

  ifm_strip_feeder dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int pix_idx, exp_strip, exp_col, acc_cnt, valid_total;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Window row k of strip s at output column col: image row s*STRIDE+k,
  // pixel value (row*IMG_W+col) mod 256, zero below the image.
  function automatic logic [23:0] ref_win(input int s, input int k, input int col);
    logic [23:0] w;
    int r;
    w = '0;
    r = s * STRIDE + k;
    if (r < IMG_H)
      for (int j = 0; j < 3; j++) w[23-8*j -: 8] = 8'((r * IMG_W + col + j) % 256);
    return w;
  endfunction

  // Pixels the source hands over while filling strip s.
  function automatic int ref_new_px(input int s);
    int hi, lo;
    hi = (s == 0) ? ROWS : ROWS + s * STRIDE;
    lo = (s == 0) ? 0 : ROWS + (s - 1) * STRIDE;
    if (hi > IMG_H) hi = IMG_H;
    if (lo > IMG_H) lo = IMG_H;
    return (hi - lo) * IMG_W;
  endfunction

  function automatic logic [23:0] pe_of(input int k);
    case (k)
      0: return bus.pe_1;
      1: return bus.pe_2;
      2: return bus.pe_3;
      3: return bus.pe_4;
      4: return bus.pe_5;
      5: return bus.pe_6;
      default: return bus.pe_7;
    endcase
  endfunction

  task automatic drive_src(input bit gaps, input bit hold);
    if (hold) return;
    bus.s_valid = gaps ? ($urandom_range(0, 99) >= 30) : 1'b1;
    bus.s_data  = bus.s_valid ? 8'(pix_idx) : 8'($urandom);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 1'b0);
    chk({tag, "_pe_valid"}, bus.pe_valid, 1'b0);
    chk({tag, "_strip_done"}, bus.strip_done, 1'b0);
    chk({tag, "_frame_done"}, bus.frame_done, 1'b0);
    chk({tag, "_busy"}, bus.busy, 1'b0);
  endtask

  // One frame; optional start pulse while busy and optional reset mid-EMIT.
  task automatic run_frame(input bit gaps, input int busy_start_at,
                           input int rst_strip, input int rst_col);
    bit done, acc, hold, aborted;
    int cyc;
    pix_idx = 0; exp_strip = 0; exp_col = 0; acc_cnt = 0; valid_total = 0;
    done = 0; aborted = 0; cyc = 0;
    bus.start = 1'b1;
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("busy_after_start", bus.busy, 1'b1);
    drive_src(gaps, 1'b0);
    while (!done && cyc < 12000) begin
      if (exp_col == OUT_W) begin
        chk($sformatf("strip%0d_done", exp_strip), bus.strip_done, 1'b1);
        chk($sformatf("strip%0d_pe_valid_low", exp_strip), bus.pe_valid, 1'b0);
        chk($sformatf("strip%0d_frame_done", exp_strip), bus.frame_done, exp_strip == N_STRIPS - 1);
        chk($sformatf("strip%0d_pixels", exp_strip), acc_cnt, ref_new_px(exp_strip));
        acc_cnt = 0;
        if (exp_strip == N_STRIPS - 1) begin
          chk("busy_at_frame_done", bus.busy, 1'b0);
          chk("windows_per_frame", valid_total, N_STRIPS * OUT_W);
          done = 1;
        end
        exp_strip++;
        exp_col = 0;
      end else begin
        chk("stray_strip_done", bus.strip_done, 1'b0);
        chk("stray_frame_done", bus.frame_done, 1'b0);
        if (exp_col > 0) chk("pe_valid_run", bus.pe_valid, 1'b1);
        if (bus.pe_valid) begin
          chk("window_after_frame", exp_strip < N_STRIPS, 1'b1);
          for (int k = 0; k < ROWS; k++)
            chk($sformatf("s%0d_c%0d_pe_%0d", exp_strip, exp_col, k + 1),
                pe_of(k), ref_win(exp_strip, k, exp_col));
          chk("s_ready_in_emit", bus.s_ready, 1'b0);
          chk("busy_in_emit", bus.busy, 1'b1);
          if (exp_strip == 0 && exp_col == 0) begin
            chk("first_pe_1", bus.pe_1, 24'h000102);
            chk("first_pe_2", bus.pe_2, 24'h323334);
            chk("first_pe_7", bus.pe_7, 24'h2C2D2E);
          end
          if (exp_strip == 1 && exp_col == 0) begin
            chk("strip2_pe_1", bus.pe_1, 24'hFAFBFC);
            chk("strip2_pe_3", bus.pe_3, 24'h5E5F60);
          end
          if (exp_strip == N_STRIPS - 1) begin
            chk("last_pe_6_zero", bus.pe_6, 24'h0);
            chk("last_pe_7_zero", bus.pe_7, 24'h0);
          end
          if (exp_strip == rst_strip && exp_col == rst_col) aborted = 1;
          exp_col++;
          valid_total++;
        end
      end
      acc = bus.s_valid && bus.s_ready;
      if (acc) begin
        pix_idx++;
        acc_cnt++;
      end
      hold = bus.s_valid && !acc;
      bus.start = (cyc == busy_start_at);
      if (aborted) rstn = 1'b0;
      @(posedge clk); #1;
      cyc++;
      if (aborted) begin
        rstn = 1'b1;
        bus.start = 1'b0;
        chk("rst_pe_valid", bus.pe_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_pe_1", bus.pe_1, 24'h0);
        done = 1;
      end else begin
        drive_src(gaps, hold);
      end
    end
    bus.start = 1'b0;
    if (!done) chk("frame_timeout", cyc, 0);
    if (!aborted) begin
      bus.s_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
        @(posedge clk); #1;
        check_idle_outputs("post_frame");
      end
    end
    bus.s_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0;
    bus.s_valid = 1'b0;
    bus.s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    chk("reset_pe_1", bus.pe_1, 24'h0);
    chk("reset_pe_7", bus.pe_7, 24'h0);
    rstn = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("idle");

    // Continuous stream.
    run_frame(1'b0, -1, -1, -1);
    // Random source gaps with a start pulse while busy.
    run_frame(1'b1, 1500, -1, -1);
    // Reset in the middle of the third strip's emission.
    run_frame(1'b0, -1, 2, 20);
    // Fresh frame after reset must reproduce the full sequence.
    run_frame(1'b0, 40, -1, -1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ifm_strip_feeder.md
Name: ifm_strip_feeder

Overview:
- Upstream stage of the 5x3 PE convolution array. Takes the input feature map (IFM) as an 8-bit pixel stream from the DMA and buffers 7 image rows.
- Slides a 3-column window across those rows and drives pe_1..pe_7 (3 pixels per row) with pe_valid, one window per cycle, so the array produces 5 output rows per strip.
- Reuses the 2 overlapping rows between strips. Zero-pads rows below the image bottom.

Parameters:
- IMG_W, 50, IFM row width in pixels; output width OUT_W = IMG_W-2 = 48.
- IMG_H, 50, IFM rows per frame; output rows OUT_H = IMG_H-2 = 48.
- ROWS, 7, rows held per strip (fixed by the PE array: 5 outputs + 2 kernel overlap).
- STRIDE, 5, new rows per strip after the first.

Ports:
- clk  in  1  clock
- rstn  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse, begins a frame; ignored while busy=1
- s_data  in  8  IFM pixel, raster order (row-major)
- s_valid  in  1  s_data valid
- s_ready  out  1  pixel accepted when s_valid && s_ready
- pe_1..pe_7  out  24 each  window row k: [23:16]=col c, [15:8]=col c+1, [7:0]=col c+2
- pe_valid  out  1  pe_1..pe_7 hold a valid window
- strip_done  out  1  one-cycle pulse after the last window of a strip
- frame_done  out  1  one-cycle pulse after the last window of the frame
- busy  out  1  high from accepted start until frame_done

Behaviour:
- Reset: state IDLE. s_ready, pe_valid, strip_done, frame_done, busy = 0. pe_1..pe_7 = 0. base = 0, in_row = 0, strip_cnt = 0, row_ok = 7'b0.
- Storage: 7 banks x IMG_W bytes. Logical row k (0..6) maps to physical bank (base+k) mod 7.
- row_ok[bank] = 1 only when that bank holds real image data. Banks with row_ok = 0 read as 0x00.
- IDLE: on start go to FILL. need = 7. busy = 1.
- FILL:
  - s_ready = 1 while need > 0 and in_row < IMG_H.
  - Each accepted pixel writes bank (base+7-need) at column col. col increments and wraps at IMG_W-1.
  - On wrap: set row_ok for that bank, then in_row++ and need--.
  - If in_row == IMG_H while need > 0: s_ready = 0. Clear row_ok for the remaining banks, one per cycle, decrementing need (zero pad).
  - When need == 0, go to EMIT.
- EMIT:
  - s_ready = 0. Column counter c runs 0..OUT_W-1, one per cycle, with no stall (the PE array has no back-pressure).
  - Outputs are registered: the first pe_valid is 1 cycle after EMIT entry, then OUT_W consecutive cycles of pe_valid = 1.
  - The cycle after the last window: pe_valid = 0, strip_done = 1, strip_cnt++.
  - If strip_cnt+1 == ceil(OUT_H/STRIDE) = 10: frame_done = 1 in the same cycle, go to IDLE, busy = 0, base = 0, in_row = 0.
  - Otherwise: base = (base+5) mod 7, need = 5, go to FILL.
- pe_* hold their last value when pe_valid = 0. Consumers must qualify with pe_valid.
- s_valid arriving while s_ready = 0 is not consumed. The source holds it.
- Pixels after the frame's IMG_H rows are not accepted; s_ready stays 0 until the next start.
- A start pulse when busy = 1 has no effect.
- Reset mid-frame (any state) returns to the reset condition on the next edge. No partial strip is emitted after reset.
- Window count per frame = 10 x 48 = 480. The last strip covers rows 45..51; rows 50 and 51 are zero.

Decomposition:
- Shared package (conv_pkg):
  - constants IMG_W, IMG_H, ROWS = 7, STRIDE = 5, OUT_W, N_STRIPS.
  - state enum {IDLE, FILL, EMIT}.
  - The conv module uses the same OUT_W/OUT_H constants to size its OFM buffer (2304 = 48x48).
- One sub-module: row_bank_mem. This is one IMG_W x 8 register row with a write port and 3 adjacent combinational read taps at c, c+1, c+2. It is instantiated 7 times.
- The FSM, the bank rotation and the output registers live in the top module.

Test Plan:
- Pixel(r,c) = (r*50+c) mod 256, s_valid always high, start pulse. First window: pe_1 = 24'h000102, pe_2 = 24'h323334, pe_7 = 24'h2C2D2E. pe_valid runs 48 cycles. strip_done pulses once.
- Strip 2 (base rotated), first window: pe_1 = row5 = 24'hFAFBFC, pe_3 = row7 = 24'h5E5F60. Exactly 250 pixels are accepted for this strip (need = 5).
- Strip 10 (rows 45..51): pe_6 = pe_7 = 24'h000000 on all 48 windows. frame_done pulses with the final strip_done. Total pe_valid count = 480. busy falls.
- Random s_valid gaps (about 30% idle) during FILL: window contents are identical to the no-gap run. s_ready = 0 throughout EMIT, and a held pixel is not lost.
- rstn low for 1 cycle mid-EMIT of strip 3: pe_valid = 0 the next cycle and busy = 0. A new start reproduces the strip 1 values exactly.
- start pulsed while busy: no restart; the frame completes with 480 windows.
